// File: rtl/arm_dp_pkg.sv
// rtl/arm_dp_pkg.sv - shared encodings and widths for the DP shifter operand path
package arm_dp_pkg;

   localparam int OP_W  = 32;
   localparam int AMT_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RS_RD,
      ST_RS_CAP,
      ST_SHIFT,
      ST_RESP
   } seq_state_t;

   typedef enum logic [1:0] {
      SH_LSL = 2'b00,
      SH_LSR = 2'b01,
      SH_ASR = 2'b10,
      SH_ROR = 2'b11
   } shift_type_t;

endpackage

// File: rtl/dp_shift_seq_if.sv
// rtl/dp_shift_seq_if.sv - request, Rs read port and result handshake of the shift sequencer
interface dp_shift_seq_if
   import arm_dp_pkg::*;
#(
   parameter int RF_ADDR_W = 4
);
   logic                 req_valid;
   logic                 req_ready;
   logic                 is_DPIS;
   logic                 is_DPRS;
   logic [1:0]           shift_type;
   logic [4:0]           imm_shift;
   logic [RF_ADDR_W-1:0] rs_sel;
   logic [OP_W-1:0]      Rm_data;
   logic                 C;
   logic                 flush;
   logic                 rs_rd_en;
   logic [RF_ADDR_W-1:0] rs_rd_addr;
   logic [OP_W-1:0]      rs_rd_data;
   logic                 res_valid;
   logic                 res_ready;
   logic [OP_W-1:0]      shifter_operand;
   logic                 shifter_carry_out;

   modport master (
      output req_valid, is_DPIS, is_DPRS, shift_type, imm_shift, rs_sel, Rm_data, C, flush,
      output rs_rd_data, res_ready,
      input  req_ready, rs_rd_en, rs_rd_addr, res_valid, shifter_operand, shifter_carry_out
   );

   modport slave (
      input  req_valid, is_DPIS, is_DPRS, shift_type, imm_shift, rs_sel, Rm_data, C, flush,
      input  rs_rd_data, res_ready,
      output req_ready, rs_rd_en, rs_rd_addr, res_valid, shifter_operand, shifter_carry_out
   );

endinterface

// File: rtl/dp_shift_unit.sv
// rtl/dp_shift_unit.sv - combinational ARM mode-1 shifter: four per-type units and a type mux
module dp_shift_lsl
   import arm_dp_pkg::*;
(
   input  logic [AMT_W-1:0] amt,
   input  logic [OP_W-1:0]  rm,
   input  logic             c,
   output logic [OP_W:0]    res
);
   // The extra top bit collects the last bit shifted out; amounts past 32 leave zero.
   always_comb begin
      if (amt == '0) res = {c, rm};
      else           res = {1'b0, rm} << amt;
   end
endmodule

module dp_shift_lsr
   import arm_dp_pkg::*;
(
   input  logic [AMT_W-1:0] amt,
   input  logic [OP_W-1:0]  rm,
   input  logic             c,
   input  logic             dpis,
   output logic [OP_W:0]    res
);
   logic [AMT_W-1:0] eff;
   logic [OP_W:0]    t;

   always_comb begin
      eff = (dpis && amt == '0) ? 8'd32 : amt;
      t   = {rm, 1'b0} >> eff;
      res = (eff == '0) ? {c, rm} : {t[0], t[OP_W:1]};
   end
endmodule

module dp_shift_asr
   import arm_dp_pkg::*;
(
   input  logic [AMT_W-1:0] amt,
   input  logic [OP_W-1:0]  rm,
   input  logic             c,
   input  logic             dpis,
   output logic [OP_W:0]    res
);
   logic [AMT_W-1:0]    eff;
   logic signed [OP_W:0] sx;
   logic [OP_W:0]       t;

   // Clamping at 32 already yields full sign fill with carry = Rm[31].
   always_comb begin
      eff = (dpis && amt == '0) ? 8'd32 : amt;
      sx  = {rm, 1'b0};
      t   = sx >>> ((eff > 8'd32) ? 8'd32 : eff);
      res = (eff == '0) ? {c, rm} : {t[0], t[OP_W:1]};
   end
endmodule

module dp_shift_ror
   import arm_dp_pkg::*;
(
   input  logic [AMT_W-1:0] amt,
   input  logic [OP_W-1:0]  rm,
   input  logic             c,
   input  logic             dpis,
   output logic [OP_W:0]    res
);
   logic [OP_W-1:0] rot;

   // After a rotate the carry is always the new bit 31, which also covers multiples of 32.
   always_comb begin
      rot = OP_W'({rm, rm} >> amt[4:0]);
      if (dpis && amt == '0) res = {rm[0], c, rm[OP_W-1:1]};
      else if (amt == '0)    res = {c, rm};
      else                   res = {rot[OP_W-1], rot};
   end
endmodule

module dp_shift_unit
   import arm_dp_pkg::*;
(
   input  logic [AMT_W-1:0] amt,
   input  logic [OP_W-1:0]  rm,
   input  logic             c,
   input  logic             is_dpis,
   input  logic             is_dprs,
   input  shift_type_t      shift_type,
   output logic [OP_W:0]    res
);
   logic [OP_W:0] lsl_res, lsr_res, asr_res, ror_res;

   dp_shift_lsl u_lsl (.amt(amt), .rm(rm), .c(c), .res(lsl_res));
   dp_shift_lsr u_lsr (.amt(amt), .rm(rm), .c(c), .dpis(is_dpis), .res(lsr_res));
   dp_shift_asr u_asr (.amt(amt), .rm(rm), .c(c), .dpis(is_dpis), .res(asr_res));
   dp_shift_ror u_ror (.amt(amt), .rm(rm), .c(c), .dpis(is_dpis), .res(ror_res));

   always_comb begin
      if (!is_dpis && !is_dprs) begin
         res = {c, rm};
      end else begin
         case (shift_type)
            SH_LSL:  res = lsl_res;
            SH_LSR:  res = lsr_res;
            SH_ASR:  res = asr_res;
            default: res = ror_res;
         endcase
      end
   end
endmodule

// File: rtl/dp_shift_seq.sv
// rtl/dp_shift_seq.sv - multi-cycle sequencer feeding the shift unit and holding the result for the ALU
module dp_shift_seq
   import arm_dp_pkg::*;
#(
   parameter int RF_ADDR_W = 4
)(
   input  logic           clk,
   input  logic           rst_n,
   dp_shift_seq_if.slave  bus
);
   seq_state_t           state;
   logic                 req_ready_r;
   logic                 res_valid_r;
   logic                 rs_rd_en_r;
   logic [RF_ADDR_W-1:0] rs_rd_addr_r;
   logic [OP_W:0]        result_r;
   logic [AMT_W-1:0]     amt_r;
   logic [OP_W-1:0]      rm_r;
   logic                 c_r;
   shift_type_t          type_r;
   logic                 dpis_r;
   logic                 dprs_r;
   logic [OP_W:0]        unit_res;
   logic                 unused_rs_hi;

   assign unused_rs_hi = ^bus.rs_rd_data[OP_W-1:AMT_W];

   dp_shift_unit u_unit (
      .amt        (amt_r),
      .rm         (rm_r),
      .c          (c_r),
      .is_dpis    (dpis_r),
      .is_dprs    (dprs_r),
      .shift_type (type_r),
      .res        (unit_res)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         req_ready_r  <= 1'b1;
         res_valid_r  <= 1'b0;
         rs_rd_en_r   <= 1'b0;
         rs_rd_addr_r <= '0;
         result_r     <= '0;
         amt_r        <= '0;
         rm_r         <= '0;
         c_r          <= 1'b0;
         type_r       <= SH_LSL;
         dpis_r       <= 1'b0;
         dprs_r       <= 1'b0;
      end else if (bus.flush) begin
         // Abort keeps the last result register contents; only the handshakes drop.
         state       <= ST_IDLE;
         req_ready_r <= 1'b1;
         res_valid_r <= 1'b0;
         rs_rd_en_r  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.req_valid) begin
                  rm_r         <= bus.Rm_data;
                  c_r          <= bus.C;
                  type_r       <= shift_type_t'(bus.shift_type);
                  dpis_r       <= bus.is_DPIS;
                  dprs_r       <= bus.is_DPRS;
                  rs_rd_addr_r <= bus.rs_sel;
                  req_ready_r  <= 1'b0;
                  if (bus.is_DPIS) begin
                     amt_r <= {3'b000, bus.imm_shift};
                     state <= ST_SHIFT;
                  end else if (bus.is_DPRS) begin
                     rs_rd_en_r <= 1'b1;
                     state      <= ST_RS_RD;
                  end else begin
                     result_r    <= {bus.C, bus.Rm_data};
                     res_valid_r <= 1'b1;
                     state       <= ST_RESP;
                  end
               end
            end
            ST_RS_RD: begin
               rs_rd_en_r <= 1'b0;
               state      <= ST_RS_CAP;
            end
            ST_RS_CAP: begin
               amt_r <= bus.rs_rd_data[AMT_W-1:0];
               state <= ST_SHIFT;
            end
            ST_SHIFT: begin
               result_r    <= unit_res;
               res_valid_r <= 1'b1;
               state       <= ST_RESP;
            end
            ST_RESP: begin
               if (bus.res_ready) begin
                  res_valid_r <= 1'b0;
                  req_ready_r <= 1'b1;
                  state       <= ST_IDLE;
               end
            end
            default: begin
               state       <= ST_IDLE;
               req_ready_r <= 1'b1;
               res_valid_r <= 1'b0;
               rs_rd_en_r  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.req_ready         = req_ready_r;
   assign bus.res_valid         = res_valid_r;
   assign bus.rs_rd_en          = rs_rd_en_r;
   assign bus.rs_rd_addr        = rs_rd_addr_r;
   assign bus.shifter_operand   = result_r[OP_W-1:0];
   assign bus.shifter_carry_out = result_r[OP_W];

endmodule

// File: tb/tb_dp_shift_seq.sv
// tb/tb_dp_shift_seq.sv - scoreboard bench for dp_shift_seq with a reference shifter model
module tb_dp_shift_seq;

   logic clk;
   logic rst_n;
   int   cyc;
   int   n_pass;
   int   n_total;

   dp_shift_seq_if #(.RF_ADDR_W(4)) bus ();

   dp_shift_seq #(.RF_ADDR_W(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   typedef struct {
      logic [32:0] val;
      int          t_acc;
      int          lat;
   } exp_t;

   exp_t        sb[$];
   int          bp_mode;
   logic [31:0] rs_value;
   logic [3:0]  exp_rs_addr;
   logic        rs_prev_en;
   logic        in_resp;
   logic [31:0] held_op;
   logic        held_c;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] want);
      n_total++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, want, cyc);
   endfunction

   // Reference: ARM addressing mode 1 shifter operand, written from the architectural rules.
   function automatic logic [32:0] model(input logic [1:0] t, input logic dpis, input logic dprs,
                                         input logic [4:0] imm, input logic [31:0] rs,
                                         input logic [31:0] rm, input logic c);
      int          n;
      int          m;
      logic [31:0] v;
      logic        co;
      if (!dpis && !dprs) return {c, rm};
      n = dpis ? int'(imm) : int'(rs[7:0]);
      if (dpis && n == 0) begin
         if (t == 2'b00) return {c, rm};
         if (t == 2'b11) return {rm[0], c, rm[31:1]};
         n = 32;
      end
      if (n == 0) return {c, rm};
      v  = '0;
      co = 1'b0;
      if (t == 2'b00) begin
         if (n < 32)       begin v = rm << n; co = rm[32-n]; end
         else if (n == 32) co = rm[0];
      end else if (t == 2'b01) begin
         if (n < 32)       begin v = rm >> n; co = rm[n-1]; end
         else if (n == 32) co = rm[31];
      end else if (t == 2'b10) begin
         if (n < 32) begin v = $signed(rm) >>> n; co = rm[n-1]; end
         else        begin v = {32{rm[31]}};      co = rm[31];  end
      end else begin
         m = n % 32;
         if (m == 0) begin v = rm; co = rm[31]; end
         else begin v = (rm >> m) | (rm << (32 - m)); co = rm[m-1]; end
      end
      return {co, v};
   endfunction

   // Result acceptance with a selectable backpressure pattern.
   initial begin
      bus.res_ready = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         if (bp_mode == 0)      bus.res_ready = ($urandom_range(0, 2) != 0);
         else if (bp_mode == 1) bus.res_ready = 1'b0;
         else                   bus.res_ready = 1'b1;
      end
   end

   // Register-file read port: data is valid only in the cycle after the strobe.
   initial begin
      bus.rs_rd_data = '0;
      rs_prev_en     = 1'b0;
      forever begin
         @(negedge clk);
         if (rs_prev_en) bus.rs_rd_data = rs_value;
         else            bus.rs_rd_data = $urandom();
         if (bus.rs_rd_en) begin
            chk("rs_rd_addr", 64'(bus.rs_rd_addr), 64'(exp_rs_addr));
            chk("rs_rd_en_single", 64'(rs_prev_en), 64'(0));
         end
         rs_prev_en = bus.rs_rd_en;
      end
   end

   // Scoreboard monitor.
   initial begin
      exp_t e;
      in_resp = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.res_valid) begin
            if (!in_resp) begin
               if (sb.size() == 0) begin
                  chk("unexpected_res_valid", 64'(1), 64'(0));
               end else begin
                  e = sb.pop_front();
                  chk("operand", 64'(bus.shifter_operand), 64'(e.val[31:0]));
                  chk("carry", 64'(bus.shifter_carry_out), 64'(e.val[32]));
                  chk("latency", 64'(cyc - e.t_acc + 1), 64'(e.lat));
               end
               held_op = bus.shifter_operand;
               held_c  = bus.shifter_carry_out;
               in_resp = 1'b1;
            end else begin
               chk("hold_operand", 64'(bus.shifter_operand), 64'(held_op));
               chk("hold_carry", 64'(bus.shifter_carry_out), 64'(held_c));
               chk("req_ready_in_resp", 64'(bus.req_ready), 64'(0));
            end
            if (bus.res_ready || bus.flush) in_resp = 1'b0;
         end else begin
            in_resp = 1'b0;
         end
      end
   end

   task automatic wait_idle();
      int g = 0;
      while (!bus.req_ready && g < 300) begin
         @(posedge clk);
         #1;
         g++;
      end
      if (g >= 300) chk("wait_idle_timeout", 64'(0), 64'(1));
   endtask

   task automatic randomize_fields();
      logic [31:0] r;
      r = $urandom();
      bus.is_DPIS    = r[0];
      bus.is_DPRS    = r[1];
      bus.shift_type = r[3:2];
      bus.imm_shift  = r[8:4];
      bus.rs_sel     = r[12:9];
      bus.C          = r[13];
      bus.Rm_data    = $urandom();
   endtask

   // Called at posedge+1; returns at posedge+1 of the cycle after the accept edge.
   task automatic issue(input logic dpis, input logic dprs, input logic [1:0] t,
                        input logic [4:0] imm, input logic [3:0] rsel, input logic [31:0] rsw,
                        input logic [31:0] rm, input logic c, input logic exp_on,
                        input logic [32:0] exp_val);
      exp_t e;
      wait_idle();
      bus.is_DPIS    = dpis;
      bus.is_DPRS    = dprs;
      bus.shift_type = t;
      bus.imm_shift  = imm;
      bus.rs_sel     = rsel;
      bus.Rm_data    = rm;
      bus.C          = c;
      bus.req_valid  = 1'b1;
      rs_value       = rsw;
      exp_rs_addr    = rsel;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      randomize_fields();
      if (exp_on) begin
         e.val   = exp_val;
         e.t_acc = cyc;
         e.lat   = dpis ? 2 : (dprs ? 4 : 1);
         sb.push_back(e);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $display("%0d/%0d checks passed", n_pass, n_total);
      $fatal(1);
   end

   int amt_tab[11] = '{0, 1, 4, 31, 32, 33, 63, 64, 96, 200, 255};

   initial begin
      n_pass        = 0;
      n_total       = 0;
      cyc           = 0;
      bp_mode       = 2;
      rs_value      = '0;
      exp_rs_addr   = '0;
      rst_n         = 1'b0;
      bus.req_valid = 1'b0;
      bus.flush     = 1'b0;
      randomize_fields();

      repeat (2) @(posedge clk);
      #1;
      chk("rst_req_ready", 64'(bus.req_ready), 64'(1));
      chk("rst_res_valid", 64'(bus.res_valid), 64'(0));
      chk("rst_rs_rd_en", 64'(bus.rs_rd_en), 64'(0));
      chk("rst_rs_rd_addr", 64'(bus.rs_rd_addr), 64'(0));
      chk("rst_operand", 64'(bus.shifter_operand), 64'(0));
      chk("rst_carry", 64'(bus.shifter_carry_out), 64'(0));
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst_req_ready", 64'(bus.req_ready), 64'(1));
      chk("post_rst_res_valid", 64'(bus.res_valid), 64'(0));
      chk("post_rst_operand", 64'(bus.shifter_operand), 64'(0));

      issue(1, 0, 2'b11, 5'd4, 4'd0, 32'h0, 32'h000000F8, 1'b0, 1, 33'h1_8000000F);
      issue(1, 0, 2'b11, 5'd0, 4'd0, 32'h0, 32'h00000003, 1'b1, 1, 33'h1_80000001);
      issue(0, 0, 2'b01, 5'd9, 4'd0, 32'h0, 32'h12345678, 1'b1, 1, 33'h1_12345678);
      issue(0, 1, 2'b11, 5'd0, 4'd5, 32'h00000120, 32'h80000001, 1'b0, 1, 33'h1_80000001);
      chk("dprs_rs_rd_en_t1", 64'(bus.rs_rd_en), 64'(1));
      chk("dprs_rs_rd_addr_t1", 64'(bus.rs_rd_addr), 64'(5));
      issue(0, 1, 2'b11, 5'd0, 4'd5, 32'hFFFFFF00, 32'h5A5A0F0F, 1'b0, 1, 33'h0_5A5A0F0F);

      // Backpressure: three stalled cycles in RESP, then release.
      wait_idle();
      bp_mode = 1;
      issue(0, 0, 2'b00, 5'd0, 4'd0, 32'h0, 32'hCAFEF00D, 1'b1, 1, 33'h1_CAFEF00D);
      for (int i = 0; i < 3; i++) begin
         chk("bp_res_valid", 64'(bus.res_valid), 64'(1));
         chk("bp_req_ready", 64'(bus.req_ready), 64'(0));
         if (i < 2) begin
            @(posedge clk);
            #1;
         end
      end
      bp_mode = 2;
      @(posedge clk);
      #1;
      chk("bp_release_req_ready", 64'(bus.req_ready), 64'(1));
      chk("bp_release_res_valid", 64'(bus.res_valid), 64'(0));

      // Flush while waiting on the Rs read data.
      issue(0, 1, 2'b00, 5'd0, 4'd3, 32'h00000004, 32'h0F0F0F0F, 1'b0, 0, 33'h0);
      @(posedge clk);
      #1;
      bus.flush = 1'b1;
      @(posedge clk);
      #1;
      bus.flush = 1'b0;
      chk("flush_req_ready", 64'(bus.req_ready), 64'(1));
      chk("flush_res_valid", 64'(bus.res_valid), 64'(0));
      chk("flush_rs_rd_en", 64'(bus.rs_rd_en), 64'(0));
      chk("flush_keeps_result", 64'(bus.shifter_operand), 64'(32'hCAFEF00D));
      repeat (5) @(posedge clk);
      #1;
      chk("flush_no_result", 64'(bus.res_valid), 64'(0));

      // Flush coinciding with a request blocks the accept.
      bus.is_DPIS   = 1'b0;
      bus.is_DPRS   = 1'b0;
      bus.Rm_data   = 32'h11111111;
      bus.req_valid = 1'b1;
      bus.flush     = 1'b1;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      bus.flush     = 1'b0;
      chk("flush_req_not_taken_ready", 64'(bus.req_ready), 64'(1));
      chk("flush_req_not_taken_valid", 64'(bus.res_valid), 64'(0));
      repeat (3) @(posedge clk);
      #1;

      // Asynchronous reset while in SHIFT.
      issue(1, 0, 2'b00, 5'd3, 4'd0, 32'h0, 32'h76543210, 1'b1, 0, 33'h0);
      rst_n = 1'b0;
      #1;
      chk("arst_req_ready", 64'(bus.req_ready), 64'(1));
      chk("arst_res_valid", 64'(bus.res_valid), 64'(0));
      chk("arst_rs_rd_en", 64'(bus.rs_rd_en), 64'(0));
      chk("arst_operand", 64'(bus.shifter_operand), 64'(0));
      chk("arst_carry", 64'(bus.shifter_carry_out), 64'(0));
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("arst_no_result", 64'(bus.res_valid), 64'(0));

      // Randomized traffic against the reference model.
      bp_mode = 0;
      for (int i = 0; i < 60; i++) begin
         int          k;
         int          idx;
         int          a;
         logic [31:0] r;
         logic [31:0] rmv;
         logic [31:0] rsw;
         logic [4:0]  immv;
         logic [3:0]  rsv;
         logic [1:0]  tv;
         logic        cv;
         logic        dpv;
         logic        drv;
         k    = $urandom_range(0, 3);
         dpv  = (k == 1) || (k == 3);
         drv  = (k >= 2);
         idx  = $urandom_range(0, 11);
         a    = (idx == 11) ? $urandom_range(0, 255) : amt_tab[idx];
         r    = $urandom();
         rsw  = (r & 32'hFFFFFF00) | 32'(a & 255);
         rmv  = $urandom();
         r    = $urandom();
         tv   = r[1:0];
         cv   = r[2];
         immv = (r[3]) ? 5'd0 : r[8:4];
         rsv  = r[12:9];
         issue(dpv, drv, tv, immv, rsv, rsw, rmv, cv, 1, model(tv, dpv, drv, immv, rsw, rmv, cv));
      end

      begin
         int g = 0;
         while ((sb.size() != 0 || !bus.req_ready) && g < 500) begin
            @(posedge clk);
            #1;
            g++;
         end
      end
      chk("scoreboard_drained", 64'(sb.size()), 64'(0));
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
